pc_fetch_controller: RTL

//  Sequences the program counter and instruction fetch for the core.

---
 rtl/pc_fetch_controller.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller: owns the program counter, fetches instruction words from
// instruction memory over a req/ack handshake and presents each one to decode
// over a valid/ready handshake. Redirects on jump / taken branch at accept,
// counts retired instructions and flags a sticky error on a memory timeout.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   imem_req         fetch request (high only while fetching)
//   imem_addr        fetch address (always equals pc)
//   imem_ack         memory returns imem_data this cycle
//   imem_data        instruction word from memory
//   instr            latched instruction presented to decode
//   instr_valid      instr valid (high only while issuing)
//   instr_ready      decode accepts instr
//   branch, zero     conditional branch and its ALU zero flag
//   jump             unconditional jump
//   immed            sign-extended word offset / jump word index
//   pc               current program counter
//   retired_count    number of accepted instructions (wraps)
//   fetch_err        sticky memory-timeout flag
module pc_fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic [31:0] immed,
  output logic [31:0] pc,
  output logic [31:0] retired_count,
  output logic        fetch_err
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [XLEN-1:0] PC_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [XLEN-1:0]   pc_d, instr_d, retired_d;
  logic [XLEN-1:0]   seq_pc, br_pc, jmp_pc;
  logic [WAIT_W-1:0] wait_cnt, wait_d;
  logic              req_d, valid_d, err_d;

  // Candidate next-PC values; the shift by 2 drops the top two immed bits.
  assign seq_pc    = pc + XLEN'(4);
  assign jmp_pc    = immed << 2;
  assign br_pc     = seq_pc + jmp_pc;
  assign imem_addr = pc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state;
    pc_d      = pc;
    instr_d   = instr;
    wait_d    = wait_cnt;
    retired_d = retired_count;
    err_d     = fetch_err;
    case (state)
      IDLE: begin
        state_d = FETCH;
        wait_d  = '0;
      end
      FETCH: begin
        // An ack in the final allowed cycle still counts as a successful fetch.
        if (imem_ack) begin
          instr_d = imem_data;
          state_d = ISSUE;
        end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_cnt + WAIT_W'(1);
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          retired_d = retired_count + XLEN'(1);
          if (jump)               pc_d = jmp_pc & PC_MASK;
          else if (branch & zero) pc_d = br_pc & PC_MASK;
          else                    pc_d = seq_pc & PC_MASK;
          state_d = FETCH;
          wait_d  = '0;
        end
      end
      ERROR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake outputs are registered from the upcoming state.
    req_d   = (state_d == FETCH);
    valid_d = (state_d == ISSUE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= RESET_PC & PC_MASK;
      instr         <= '0;
      wait_cnt      <= '0;
      retired_count <= '0;
      fetch_err     <= 1'b0;
      imem_req      <= 1'b0;
      instr_valid   <= 1'b0;
    end else begin
      pc            <= pc_d;
      instr         <= instr_d;
      wait_cnt      <= wait_d;
      retired_count <= retired_d;
      fetch_err     <= err_d;
      imem_req      <= req_d;
      instr_valid   <= valid_d;
    end
  end

endmodule
